// File: rtl/data_mem_lsu.sv
// Data memory with an integrated RV32I load/store unit: one request in flight,
// byte-lane merging on stores, sign/zero extension on loads, error flagging.
module data_mem_lsu #(
   parameter int unsigned DEPTH_WORDS = 256,
   parameter int unsigned CNT_W       = 8,
   parameter string       INIT_FILE   = ""
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_we,
   input  logic [2:0]       req_funct3,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   output logic             resp_valid,
   output logic [31:0]      resp_rdata,
   output logic             resp_err,
   output logic [CNT_W-1:0] err_count
);

   localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [31:0] mem [DEPTH_WORDS];

   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic          accept_c;
   logic          in_range_c;
   logic          err_c;
   logic          mem_wr_c;
   logic [AW-1:0] widx_c;
   logic [31:0]   word_c;
   logic [3:0]    be_c;
   logic [31:0]   wlane_c;
   logic [31:0]   wmask_c;
   logic [31:0]   merged_c;
   logic [7:0]    byte_c;
   logic [15:0]   half_c;
   logic [31:0]   ld_c;

   logic             valid_d;
   logic             err_d;
   logic [31:0]      rdata_d;
   logic [CNT_W-1:0] cnt_d;

   assign req_ready  = (state_q == IDLE) && !reset;
   assign accept_c   = req_valid && req_ready;
   assign widx_c     = addr_q[AW+1:2];
   assign word_c     = mem[widx_c];
   assign in_range_c = {2'b00, addr_q[31:2]} < 32'(DEPTH_WORDS);

   // Request rejection: bad width code for the direction, misalignment, or out of range
   always_comb begin
      err_c = 1'b0;
      case (f3_q)
         3'b000:         err_c = 1'b0;
         3'b001:         err_c = addr_q[0];
         3'b010:         err_c = (addr_q[1:0] != 2'b00);
         3'b100, 3'b101: err_c = we_q || (f3_q[0] && addr_q[0]);
         default:        err_c = 1'b1;
      endcase
      if (!in_range_c) err_c = 1'b1;
   end

   // Store lane replication and byte enables
   always_comb begin
      be_c    = 4'b1111;
      wlane_c = wdata_q;
      case (f3_q[1:0])
         2'b00: begin
            be_c    = 4'(4'b0001 << addr_q[1:0]);
            wlane_c = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be_c    = addr_q[1] ? 4'b1100 : 4'b0011;
            wlane_c = {2{wdata_q[15:0]}};
         end
         default: be_c = 4'b1111;
      endcase
      wmask_c  = {{8{be_c[3]}}, {8{be_c[2]}}, {8{be_c[1]}}, {8{be_c[0]}}};
      merged_c = (word_c & ~wmask_c) | (wlane_c & wmask_c);
   end

   // Load lane extraction and extension
   always_comb begin
      byte_c = 8'(word_c >> {addr_q[1:0], 3'b000});
      half_c = addr_q[1] ? word_c[31:16] : word_c[15:0];
      case (f3_q)
         3'b000:  ld_c = {{24{byte_c[7]}}, byte_c};
         3'b001:  ld_c = {{16{half_c[15]}}, half_c};
         3'b100:  ld_c = {24'h0, byte_c};
         3'b101:  ld_c = {16'h0, half_c};
         default: ld_c = word_c;
      endcase
   end

   // Next-state and registered-output values
   always_comb begin
      state_d  = state_q;
      valid_d  = 1'b0;
      err_d    = resp_err;
      rdata_d  = resp_rdata;
      cnt_d    = err_count;
      mem_wr_c = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept_c) state_d = ACCESS;
         end
         ACCESS: begin
            state_d  = RESP;
            valid_d  = 1'b1;
            err_d    = err_c;
            rdata_d  = (err_c || we_q) ? 32'h0 : ld_c;
            mem_wr_c = we_q && !err_c && !reset;
            if (err_c && (err_count != CNT_MAX)) cnt_d = err_count + CNT_W'(1);
         end
         RESP: begin
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 32'h0;
         err_count  <= '0;
      end else begin
         state_q    <= state_d;
         resp_valid <= valid_d;
         resp_err   <= err_d;
         resp_rdata <= rdata_d;
         err_count  <= cnt_d;
      end
   end

   // Request capture; only meaningful once accepted
   always_ff @(posedge clk) begin
      if (accept_c) begin
         we_q    <= req_we;
         f3_q    <= req_funct3;
         addr_q  <= req_addr;
         wdata_q <= req_wdata;
      end
   end

   // RAM contents survive reset; the write itself is gated off during reset
   always_ff @(posedge clk) begin
      if (mem_wr_c) mem[widx_c] <= merged_c;
   end

endmodule

// File: tb/tb_data_mem_lsu.sv
// Scoreboard bench for data_mem_lsu: byte-array reference model, queued
// expectations, and an independent response monitor.
module tb_data_mem_lsu;

   localparam int unsigned DEPTH  = 64;
   localparam int unsigned CW     = 2;
   localparam int unsigned NBYTES = 4 * DEPTH;
   localparam int unsigned CMAX   = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          req_valid = 1'b0;
   logic          req_ready;
   logic          req_we = 1'b0;
   logic [2:0]    req_funct3 = 3'd0;
   logic [31:0]   req_addr = 32'h0;
   logic [31:0]   req_wdata = 32'h0;
   logic          resp_valid;
   logic [31:0]   resp_rdata;
   logic          resp_err;
   logic [CW-1:0] err_count;

   always #5 clk = ~clk;

   data_mem_lsu #(.DEPTH_WORDS(DEPTH), .CNT_W(CW), .INIT_FILE("")) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .err_count  (err_count)
   );

   typedef struct {
      logic        err;
      logic [31:0] rdata;
      int unsigned cnt;
      int unsigned cyc;
   } exp_t;

   exp_t        sbq[$];
   exp_t        mon_e;
   logic [7:0]  mref [NBYTES];
   int unsigned mcnt = 0;
   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_now(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s (cycle %0d)", name, cyc);
   endtask

   // Reference behaviour: memory as little-endian bytes, arithmetic extension
   function automatic void model(input logic we, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, output logic err, output logic [31:0] rd);
      int unsigned sz;
      logic legal;
      sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      err = !legal || ((a % sz) != 0) || (a >= NBYTES);
      rd = 32'h0;
      if (err) begin
         if (mcnt < CMAX) mcnt++;
      end else if (we) begin
         for (int i = 0; i < int'(sz); i++) mref[a + 32'(i)] = 8'(wd >> (8 * i));
      end else begin
         for (int i = 0; i < int'(sz); i++) rd = rd | (32'(mref[a + 32'(i)]) << (8 * i));
         if (!f3[2] && sz < 4 && rd[8 * sz - 1]) rd = rd | (32'hFFFF_FFFF << (8 * sz));
      end
   endfunction

   task automatic push_exp(input logic we, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input bit has_exp, input logic [31:0] exp_rd);
      exp_t e;
      logic err;
      logic [31:0] rd;
      model(we, f3, a, wd, err, rd);
      e.err   = err;
      e.rdata = has_exp ? exp_rd : rd;
      e.cnt   = mcnt;
      e.cyc   = cyc + 2;
      sbq.push_back(e);
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input bit has_exp = 1'b0,
                        input logic [31:0] exp_rd = 32'h0, input bit push = 1'b1);
      int n;
      @(negedge clk);
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      n = 0;
      while (!req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         fail_now("accept_timeout");
         req_valid = 1'b0;
      end else begin
         if (push) push_exp(we, f3, a, wd, has_exp, exp_rd);
         @(negedge clk);
         req_valid = 1'b0;
      end
   endtask

   // Response monitor
   always @(negedge clk) begin
      if (resp_valid) begin
         if (sbq.size() == 0) begin
            fail_now("spurious_resp");
         end else begin
            mon_e = sbq.pop_front();
            check("resp_err", 32'(resp_err), 32'(mon_e.err));
            check("resp_rdata", resp_rdata, mon_e.rdata);
            check("err_count", 32'(err_count), mon_e.cnt);
            check("resp_latency", cyc, mon_e.cyc);
         end
      end
   end

   logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

   initial begin
      int n;
      logic        r_we;
      logic [2:0]  r_f3;
      logic [31:0] r_a;

      // Request held through reset must wait for the first post-reset cycle
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_funct3 = 3'd2;
      req_addr   = 32'h0;
      req_wdata  = 32'hCAFE_0001;
      repeat (3) begin
         @(negedge clk);
         check("ready_in_reset", 32'(req_ready), 32'h0);
      end
      check("rst_resp_valid", 32'(resp_valid), 32'h0);
      check("rst_resp_err", 32'(resp_err), 32'h0);
      check("rst_resp_rdata", resp_rdata, 32'h0);
      check("rst_err_count", 32'(err_count), 32'h0);
      reset = 1'b0;
      #1;
      check("ready_after_reset", 32'(req_ready), 32'h1);
      push_exp(1'b1, 3'd2, 32'h0, 32'hCAFE_0001, 1'b0, 32'h0);
      @(negedge clk);
      req_valid = 1'b0;

      for (int w = 0; w < int'(DEPTH); w++) issue(1'b1, 3'd2, 32'(4 * w), $urandom);

      // Directed lane tests
      issue(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF);
      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEAD_BEEF);
      issue(1'b0, 3'd0, 32'h13, 32'h0, 1'b1, 32'hFFFF_FFDE);
      issue(1'b0, 3'd4, 32'h13, 32'h0, 1'b1, 32'h0000_00DE);
      issue(1'b1, 3'd0, 32'h11, 32'hFFFF_FF55);
      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'hDEAD_55EF);
      issue(1'b1, 3'd1, 32'h12, 32'h0000_1234);
      issue(1'b0, 3'd1, 32'h12, 32'h0, 1'b1, 32'h0000_1234);
      issue(1'b0, 3'd5, 32'h10, 32'h0, 1'b1, 32'h0000_55EF);

      // Error requests and counter saturation (2-bit counter)
      issue(1'b0, 3'd2, 32'h02, 32'h0, 1'b1, 32'h0);
      @(negedge clk);
      check("err_count_first", 32'(err_count), 32'h1);
      issue(1'b1, 3'd1, 32'h11, 32'h0000_BEEF, 1'b1, 32'h0);
      issue(1'b0, 3'd2, 32'h10, 32'h0, 1'b1, 32'h1234_55EF);
      issue(1'b0, 3'd2, 32'(NBYTES), 32'h0, 1'b1, 32'h0);
      @(negedge clk);
      check("err_count_third", 32'(err_count), 32'h3);
      issue(1'b0, 3'd3, 32'h10, 32'h0, 1'b1, 32'h0);
      issue(1'b1, 3'd4, 32'h10, 32'h0, 1'b1, 32'h0);
      @(negedge clk);
      check("err_count_sat", 32'(err_count), 32'h3);

      // Reset during ACCESS of a store drops the write and the response
      issue(1'b1, 3'd2, 32'h20, 32'h1111_1111);
      issue(1'b1, 3'd2, 32'h20, 32'hAAAA_AAAA, 1'b0, 32'h0, 1'b0);
      reset = 1'b1;
      #1;
      check("ready_in_mid_reset", 32'(req_ready), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      mcnt  = 0;
      check("mid_rst_err_count", 32'(err_count), 32'h0);
      check("mid_rst_resp_valid", 32'(resp_valid), 32'h0);
      @(negedge clk);
      check("mid_rst_no_resp", 32'(resp_valid), 32'h0);
      issue(1'b0, 3'd2, 32'h20, 32'h0, 1'b1, 32'h1111_1111);

      // req_valid held high: ready must pulse 1,0,0 and only ready cycles are taken
      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 12; i++) begin
         r_we = 1'($urandom_range(0, 1));
         r_f3 = f3s[$urandom_range(0, 4)];
         r_a  = 32'($urandom_range(0, NBYTES - 1));
         req_valid  = 1'b1;
         req_we     = r_we;
         req_funct3 = r_f3;
         req_addr   = r_a;
         req_wdata  = $urandom;
         check("ready_pattern", 32'(req_ready), (i % 3 == 0) ? 32'h1 : 32'h0);
         if (req_ready) push_exp(r_we, r_f3, r_a, req_wdata, 1'b0, 32'h0);
         @(negedge clk);
      end
      req_valid = 1'b0;

      // Randomized mix, including illegal codes and wild addresses
      for (int k = 0; k < 300; k++) begin
         r_we = 1'($urandom_range(0, 1));
         r_f3 = ($urandom_range(0, 7) == 0) ? 3'($urandom) : f3s[$urandom_range(0, 4)];
         r_a  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, NBYTES + 15));
         issue(r_we, r_f3, r_a, $urandom);
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end

      n = 0;
      while (sbq.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (sbq.size() != 0) fail_now("missing_responses");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
